// File: rtl/rtm_port_resp_pkg.sv
// Shared RTM geometry: lane count, bytes per bank word and bank depth.
package rtm_port_resp_pkg;
  localparam int S         = 8;
  localparam int R         = 16;
  localparam int RTM_DEPTH = 64;
  localparam int RTM_AW    = $clog2(RTM_DEPTH);
endpackage

// File: rtl/rtm_port_resp_bank.sv
// Simple dual-port activation bank: read-first, two registered read stages.
module rtm_bank #(
  parameter  int W     = 128,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem [0:DEPTH-1];
  logic [W-1:0] data_p0;
  logic [W-1:0] data_p1;
  logic         wr_ok;

  // Out-of-range addresses (non power-of-two depth) never reach the array.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH[AW:0]);

  // p0: array read sampled on the same edge as any write, so reads see old data
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) data_p0 <= mem[rd_addr];
    // p1: bank output register
    data_p1 <= data_p0;
  end

  assign rd_data = data_p1;
endmodule

// File: rtl/rtm_port_resp.sv
// RTM port responder: S banks, fixed-latency read return with vld/last framing.
module rtm_port_resp
  import rtm_port_resp_pkg::*;
#(
  parameter  int S_LANES = S,
  parameter  int R_BYTES = R,
  parameter  int DEPTH   = RTM_DEPTH,
  parameter  int RD_LAT  = 3,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = R_BYTES * 8,
  localparam int DW      = S_LANES * LW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rtm_rd_vld,
  input  logic                  rtm_rd_last,
  input  logic [S_LANES-1:0]    rtm_rd_en,
  input  logic [S_LANES*AW-1:0] rtm_rd_addr,
  output logic [DW-1:0]         rtm_dout,
  output logic                  rtm_dout_vld,
  output logic                  rtm_dout_last,
  input  logic                  rtm_wr_vld,
  input  logic [S_LANES-1:0]    rtm_wr_en,
  input  logic [S_LANES*AW-1:0] rtm_wr_addr,
  input  logic [DW-1:0]         rtm_din,
  output logic                  rd_busy,
  output logic                  coll_err
);
  logic                 issue;
  logic                 wr_go;
  logic [DW-1:0]        bank_q;
  logic [DW-1:0]        data_out;
  logic [S_LANES-1:0]   lane_hit;
  logic [RD_LAT-1:0]    vld_q;
  logic [RD_LAT-1:0]    last_q;
  logic [S_LANES-1:0]   en_q [RD_LAT];

  assign issue = rtm_rd_vld & ~rst;
  assign wr_go = rtm_wr_vld & ~rst;

  for (genvar i = 0; i < S_LANES; i++) begin : g_lane
    rtm_bank #(.W(LW), .DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .rd_en   (issue & rtm_rd_en[i]),
      .rd_addr (rtm_rd_addr[i*AW +: AW]),
      .rd_data (bank_q[i*LW +: LW]),
      .wr_en   (wr_go & rtm_wr_en[i]),
      .wr_addr (rtm_wr_addr[i*AW +: AW]),
      .wr_data (rtm_din[i*LW +: LW])
    );

    assign lane_hit[i] = issue & rtm_rd_en[i] & wr_go & rtm_wr_en[i] &
                         (rtm_rd_addr[i*AW +: AW] == rtm_wr_addr[i*AW +: AW]);

    assign rtm_dout[i*LW +: LW] = (vld_q[RD_LAT-1] & en_q[RD_LAT-1][i]) ?
                                  data_out[i*LW +: LW] : '0;
  end

  // p0..p(RD_LAT-1): framing chain, length matches the data path exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      last_q   <= '0;
      coll_err <= 1'b0;
    end else begin
      vld_q  <= {vld_q[RD_LAT-2:0], issue};
      last_q <= {last_q[RD_LAT-2:0], issue & rtm_rd_last};
      if (|lane_hit) coll_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    en_q[0] <= rtm_rd_en;
    for (int k = 1; k < RD_LAT; k++) en_q[k] <= en_q[k-1];
  end

  // Extra output stages beyond the bank's own two registers
  if (RD_LAT == 2) begin : g_no_extra
    assign data_out = bank_q;
  end else begin : g_extra
    logic [DW-1:0] data_p [RD_LAT-2];
    always_ff @(posedge clk) begin
      data_p[0] <= bank_q;
      for (int k = 1; k < RD_LAT - 2; k++) data_p[k] <= data_p[k-1];
    end
    assign data_out = data_p[RD_LAT-3];
  end

  assign rtm_dout_vld  = vld_q[RD_LAT-1];
  assign rtm_dout_last = last_q[RD_LAT-1];
  assign rd_busy       = issue | (|vld_q);
endmodule

// File: tb/tb_rtm_port_resp.sv
// Directed bench for rtm_port_resp with hand-computed expectations (RD_LAT = 3).
module tb_rtm_port_resp;
  import rtm_port_resp_pkg::*;

  localparam int AW  = RTM_AW;
  localparam int LW  = R * 8;
  localparam int DW  = S * LW;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            rtm_rd_vld;
  logic            rtm_rd_last;
  logic [S-1:0]    rtm_rd_en;
  logic [S*AW-1:0] rtm_rd_addr;
  logic [DW-1:0]   rtm_dout;
  logic            rtm_dout_vld;
  logic            rtm_dout_last;
  logic            rtm_wr_vld;
  logic [S-1:0]    rtm_wr_en;
  logic [S*AW-1:0] rtm_wr_addr;
  logic [DW-1:0]   rtm_din;
  logic            rd_busy;
  logic            coll_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] val_a = {16{8'hA5}};
  logic [LW-1:0] val_b = {16{8'h3C}};

  always #5 clk = ~clk;

  rtm_port_resp #(.RD_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .rtm_rd_vld    (rtm_rd_vld),
    .rtm_rd_last   (rtm_rd_last),
    .rtm_rd_en     (rtm_rd_en),
    .rtm_rd_addr   (rtm_rd_addr),
    .rtm_dout      (rtm_dout),
    .rtm_dout_vld  (rtm_dout_vld),
    .rtm_dout_last (rtm_dout_last),
    .rtm_wr_vld    (rtm_wr_vld),
    .rtm_wr_en     (rtm_wr_en),
    .rtm_wr_addr   (rtm_wr_addr),
    .rtm_din       (rtm_din),
    .rd_busy       (rd_busy),
    .coll_err      (coll_err)
  );

  function automatic logic [S*AW-1:0] rep_addr(input logic [AW-1:0] a);
    return {S{a}};
  endfunction

  function automatic logic [DW-1:0] fill(input logic [LW-1:0] v);
    return {S{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rtm_rd_vld  = 1'b0;
    rtm_rd_last = 1'b0;
    rtm_rd_en   = '0;
    rtm_rd_addr = '0;
    rtm_wr_vld  = 1'b0;
    rtm_wr_en   = '0;
    rtm_wr_addr = '0;
    rtm_din     = '0;
  endtask

  task automatic do_write(input logic [S-1:0] en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    rtm_wr_vld  = 1'b1;
    rtm_wr_en   = en;
    rtm_wr_addr = rep_addr(a);
    rtm_din     = d;
    step();
    idle();
  endtask

  task automatic drive_read(input logic [S-1:0] en, input logic [AW-1:0] a, input logic last);
    idle();
    rtm_rd_vld  = 1'b1;
    rtm_rd_last = last;
    rtm_rd_en   = en;
    rtm_rd_addr = rep_addr(a);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (rtm_dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", rtm_dout_vld); end
    n_tests++;
    if (rtm_dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", rtm_dout_last); end
    n_tests++;
    if (rtm_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", rtm_dout); end
    n_tests++;
    if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rd_busy); end
    n_tests++;
    if (coll_err !== 1'b0) begin n_fail++; $display("FAIL reset_coll: got %b want 0", coll_err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < S; i++) exp_d[i*LW +: LW] = {16{8'(i + 1)}};
    do_write('1, 6'd5, exp_d);
    for (int k = 0; k < 3; k++) step();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive_read('1, 6'd5, 1'b1);
      else idle();
      #1;
      n_tests++;
      if (rtm_dout_vld !== 1'(c == LAT)) begin
        n_fail++; $display("FAIL wr_rd_vld c=%0d: got %b want %b", c, rtm_dout_vld, c == LAT);
      end
      if (c == LAT) begin
        n_tests++;
        if (rtm_dout !== exp_d) begin n_fail++; $display("FAIL wr_rd_data: got %h want %h", rtm_dout, exp_d); end
        n_tests++;
        if (rtm_dout_last !== 1'b1) begin n_fail++; $display("FAIL wr_rd_last: got %b want 1", rtm_dout_last); end
      end
      step();
    end
  endtask

  task automatic test_partial();
    logic [DW-1:0] exp_d;
    exp_d = '0;
    exp_d[0*LW +: LW] = {16{8'd1}};
    exp_d[2*LW +: LW] = {16{8'd3}};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive_read(8'b0000_0101, 6'd5, 1'b0);
      else idle();
      #1;
      n_tests++;
      if (rtm_dout_vld !== 1'(c == LAT)) begin
        n_fail++; $display("FAIL partial_vld c=%0d: got %b want %b", c, rtm_dout_vld, c == LAT);
      end
      if (c == LAT) begin
        n_tests++;
        if (rtm_dout !== exp_d) begin n_fail++; $display("FAIL partial_data: got %h want %h", rtm_dout, exp_d); end
      end
      step();
    end
  endtask

  task automatic test_burst();
    for (int a = 0; a < 16; a++) do_write('1, AW'(a), fill(LW'(a)));
    step();
    for (int c = 0; c < 22; c++) begin
      if (c < 16) drive_read('1, AW'(c), c == 15);
      else idle();
      #1;
      n_tests++;
      if (rtm_dout_vld !== 1'(c >= LAT && c < 16 + LAT)) begin
        n_fail++; $display("FAIL burst_vld c=%0d: got %b", c, rtm_dout_vld);
      end
      n_tests++;
      if (rtm_dout_last !== 1'(c == 15 + LAT)) begin
        n_fail++; $display("FAIL burst_last c=%0d: got %b", c, rtm_dout_last);
      end
      n_tests++;
      if (rd_busy !== 1'(c <= 15 + LAT)) begin
        n_fail++; $display("FAIL burst_busy c=%0d: got %b", c, rd_busy);
      end
      if (c >= LAT && c < 16 + LAT) begin
        n_tests++;
        if (rtm_dout !== fill(LW'(c - LAT))) begin
          n_fail++; $display("FAIL burst_data c=%0d: got %h want %h", c, rtm_dout, fill(LW'(c - LAT)));
        end
      end
      step();
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    exp_a = '0; exp_a[3*LW +: LW] = val_a;
    exp_b = '0; exp_b[3*LW +: LW] = val_b;
    do_write(8'b0000_1000, 6'd9, fill(val_a));
    step();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) begin
        drive_read(8'b0000_1000, 6'd9, 1'b1);
        rtm_wr_vld  = 1'b1;
        rtm_wr_en   = 8'b0000_1000;
        rtm_wr_addr = rep_addr(6'd9);
        rtm_din     = fill(val_b);
      end else if (c == 1) begin
        drive_read(8'b0000_1000, 6'd9, 1'b1);
      end
      #1;
      n_tests++;
      if (coll_err !== 1'(c >= 1)) begin n_fail++; $display("FAIL coll_err c=%0d: got %b", c, coll_err); end
      if (c == LAT) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b1 || rtm_dout !== exp_a) begin
          n_fail++; $display("FAIL coll_old: vld %b got %h want %h", rtm_dout_vld, rtm_dout, exp_a);
        end
      end
      if (c == LAT + 1) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b1 || rtm_dout !== exp_b) begin
          n_fail++; $display("FAIL coll_new: vld %b got %h want %h", rtm_dout_vld, rtm_dout, exp_b);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp9;
    exp9 = fill(LW'(9));
    exp9[3*LW +: LW] = val_b;
    for (int c = 0; c < 9; c++) begin
      rst = 1'b0;
      if (c < 4) drive_read('1, AW'(c), 1'b0);
      else idle();
      if (c == 3) rst = 1'b1;
      #1;
      if (c == LAT) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_vld: got %b want 1", rtm_dout_vld); end
      end
      if (c > 3) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b0 || rtm_dout_last !== 1'b0 || rtm_dout !== '0 ||
            rd_busy !== 1'b0 || coll_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_quiet c=%0d: vld %b last %b busy %b coll %b dout %h want all 0",
                   c, rtm_dout_vld, rtm_dout_last, rd_busy, coll_err, rtm_dout);
        end
      end
      step();
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive_read('1, 6'd7, 1'b0);
      else if (c == 1) drive_read('1, 6'd9, 1'b1);
      else idle();
      #1;
      if (c == LAT) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b1 || rtm_dout !== fill(LW'(7))) begin
          n_fail++; $display("FAIL rstmid_reread7: vld %b got %h", rtm_dout_vld, rtm_dout);
        end
      end
      if (c == LAT + 1) begin
        n_tests++;
        if (rtm_dout_vld !== 1'b1 || rtm_dout_last !== 1'b1 || rtm_dout !== exp9) begin
          n_fail++; $display("FAIL rstmid_reread9: vld %b last %b got %h want %h",
                             rtm_dout_vld, rtm_dout_last, rtm_dout, exp9);
        end
      end
      step();
    end
  endtask

  task automatic test_stray_last();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin
        rtm_rd_last = 1'b1;
        rtm_rd_en   = '1;
      end
      #1;
      n_tests++;
      if (rtm_dout_vld !== 1'b0 || rtm_dout_last !== 1'b0 || rd_busy !== 1'b0) begin
        n_fail++; $display("FAIL stray_last c=%0d: vld %b last %b busy %b want 0",
                           c, rtm_dout_vld, rtm_dout_last, rd_busy);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_partial();
    test_burst();
    test_collision();
    test_reset_mid();
    test_stray_last();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
